// File: rtl/axis_snoop_pkg.sv
// Shared types and helpers for the snoop-FIFO packet arbiter.
package axis_snoop_pkg;

   typedef enum logic {IDLE, PKT} snoop_arb_state_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] max_v;
      max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v >= max_v) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/snoop_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module snoop_rr_pick #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   rr_ptr,
   output logic [CH_W-1:0]   grant,
   output logic              any_req
);

   localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

   logic [2*NUM_CH-1:0] req_dbl;
   logic [NUM_CH-1:0]   req_rot;
   logic [CH_W-1:0]     offset;
   logic                found;
   logic [CH_W:0]       sum;

   always_comb begin
      req_dbl = {req, req} >> rr_ptr;
      req_rot = req_dbl[NUM_CH-1:0];
      offset  = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (req_rot[i] && !found) begin
            offset = CH_W'(i);
            found  = 1'b1;
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, offset};
      if (sum >= NUM_CH_L) begin
         sum = sum - NUM_CH_L;
      end
      grant   = sum[CH_W-1:0];
      any_req = |req;
   end

endmodule

// File: rtl/axis_snoop_arbiter.sv
// Packet-granular round-robin merge of NUM_CH snoop-FIFO AXIS streams into one,
// tagging each beat with its source channel and counting forwarded packets.
module axis_snoop_arbiter
   import axis_snoop_pkg::*;
#(
   parameter int  PORT_WIDTH = 8,
   parameter int  NUM_CH     = 4,
   parameter int  CNT_WIDTH  = 32,
   localparam int CH_W       = ch_width(NUM_CH)
) (
   input  logic                         AXIS_ACLK,
   input  logic                         AXIS_ARESETN,
   input  logic [NUM_CH-1:0]            S_AXIS_TVALID,
   output logic [NUM_CH-1:0]            S_AXIS_TREADY,
   input  logic [NUM_CH*PORT_WIDTH-1:0] S_AXIS_TDATA,
   input  logic [NUM_CH-1:0]            S_AXIS_TLAST,
   output logic                         M_AXIS_TVALID,
   input  logic                         M_AXIS_TREADY,
   output logic [PORT_WIDTH-1:0]        M_AXIS_TDATA,
   output logic                         M_AXIS_TLAST,
   output logic [CH_W-1:0]              M_AXIS_TDEST,
   output logic [NUM_CH*CNT_WIDTH-1:0]  PKT_CNT
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   snoop_arb_state_t state_q, state_d;
   logic [CH_W-1:0]       grant_q, grant_d;
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]       pick;
   logic                  any_req;
   logic                  out_valid_q, out_valid_d;
   logic [PORT_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic [CH_W-1:0]       out_dest_q, out_dest_d;
   logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];
   logic [63:0]           cnt_inc;
   logic [NUM_CH-1:0]     s_ready;
   logic                  accept;
   logic                  accept_last;

   snoop_rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_pick (
      .req     (S_AXIS_TVALID),
      .rr_ptr  (rr_ptr_q),
      .grant   (pick),
      .any_req (any_req)
   );

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_dest_q  <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_dest_q  <= out_dest_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Grant is locked until the TLAST beat; valid gaps on the granted channel do not release it.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = PKT;
               grant_d = pick;
            end
         end
         PKT: begin
            if (accept_last) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_ready = '0;
      if (state_q == PKT) begin
         s_ready[grant_q] = ~out_valid_q | M_AXIS_TREADY;
      end
      accept      = S_AXIS_TVALID[grant_q] & s_ready[grant_q];
      accept_last = accept & S_AXIS_TLAST[grant_q];

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_dest_d  = out_dest_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = S_AXIS_TDATA[grant_q*PORT_WIDTH +: PORT_WIDTH];
         out_last_d  = S_AXIS_TLAST[grant_q];
         out_dest_d  = grant_q;
      end else if (M_AXIS_TREADY) begin
         out_valid_d = 1'b0;
      end

      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      cnt_inc = sat_inc(64'(cnt_q[grant_q]), CNT_WIDTH);
      if (accept_last) begin
         cnt_d[grant_q] = cnt_inc[CNT_WIDTH-1:0];
      end
   end

   always_comb begin
      S_AXIS_TREADY = s_ready;
      M_AXIS_TVALID = out_valid_q;
      M_AXIS_TDATA  = out_data_q;
      M_AXIS_TLAST  = out_last_q;
      M_AXIS_TDEST  = out_dest_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         PKT_CNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

endmodule

// File: tb/tb_axis_snoop_arbiter.sv
// Bench for axis_snoop_arbiter: upstream packet queues, expected-beat scoreboard and counter model.
module tb_axis_snoop_arbiter;

   localparam int PW  = 8;
   localparam int NCH = 4;
   localparam int CW  = 32;
   localparam int CWB = 4;

   typedef struct {
      logic [7:0]  d;
      logic        l;
      int unsigned gap;
   } in_beat_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic [1:0] dest;
   } out_beat_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NCH-1:0]     s_valid, s_last;
   logic [NCH*PW-1:0]  s_data;
   logic               m_ready;
   logic [NCH-1:0]     s_ready_a, s_ready_b;
   logic               m_valid_a, m_valid_b, m_last_a, m_last_b;
   logic [PW-1:0]      m_data_a, m_data_b;
   logic [1:0]         m_dest_a, m_dest_b;
   logic [NCH*CW-1:0]  cnt_a;
   logic [NCH*CWB-1:0] cnt_b;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   in_beat_t    qin[NCH][$];
   out_beat_t   qexp[$];
   int          cnt_model[NCH];
   int unsigned head_wait[NCH];
   logic [NCH-1:0] hs;
   bit          mrdy_pat[$];
   bit          chk_en  = 1'b0;
   bit          chk_gap = 1'b0;

   axis_snoop_arbiter #(.PORT_WIDTH(PW), .NUM_CH(NCH), .CNT_WIDTH(CW)) dut_a (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
      .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready_a), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
      .M_AXIS_TVALID(m_valid_a), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data_a),
      .M_AXIS_TLAST(m_last_a), .M_AXIS_TDEST(m_dest_a), .PKT_CNT(cnt_a)
   );

   axis_snoop_arbiter #(.PORT_WIDTH(PW), .NUM_CH(NCH), .CNT_WIDTH(CWB)) dut_b (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
      .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready_b), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
      .M_AXIS_TVALID(m_valid_b), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data_b),
      .M_AXIS_TLAST(m_last_b), .M_AXIS_TDEST(m_dest_b), .PKT_CNT(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_pkt(input int ch, input logic [7:0] base, input int n,
                           input int gap_at, input int unsigned gap_len);
      for (int i = 0; i < n; i++) begin
         in_beat_t  b;
         out_beat_t e;
         b.d   = base + 8'(i);
         b.l   = (i == n - 1);
         b.gap = (i == gap_at) ? gap_len : 0;
         qin[ch].push_back(b);
         e.d    = b.d;
         e.l    = b.l;
         e.dest = 2'(ch);
         qexp.push_back(e);
      end
      cnt_model[ch]++;
   endtask

   function automatic bit pending();
      for (int ch = 0; ch < NCH; ch++) begin
         if (qin[ch].size() > 0) return 1'b1;
      end
      return (qexp.size() > 0) || m_valid_a;
   endfunction

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, 64'(n < budget), 64'd1);
   endtask

   task automatic chk_cnt(input string name);
      for (int ch = 0; ch < NCH; ch++) begin
         chk($sformatf("%s_cnt32_ch%0d", name, ch), 64'(cnt_a[ch*CW +: CW]), 64'(cnt_model[ch]));
         chk($sformatf("%s_cnt4_ch%0d", name, ch), 64'(cnt_b[ch*CWB +: CWB]),
             64'((cnt_model[ch] > 15) ? 15 : cnt_model[ch]));
      end
   endtask

   // Upstream driver: beats advance on the handshake seen just before each rising edge.
   initial begin
      s_valid = '0;
      s_data  = '0;
      s_last  = '0;
      m_ready = 1'b1;
      hs      = '0;
      for (int ch = 0; ch < NCH; ch++) head_wait[ch] = 0;
      forever begin
         @(negedge clk);
         hs = s_valid & s_ready_a;
         @(posedge clk);
         cyc++;
         #1;
         for (int ch = 0; ch < NCH; ch++) begin
            if (hs[ch] && qin[ch].size() > 0) begin
               void'(qin[ch].pop_front());
               head_wait[ch] = (qin[ch].size() > 0) ? qin[ch][0].gap : 0;
            end
            if (head_wait[ch] > 0) begin
               s_valid[ch] = 1'b0;
               head_wait[ch]--;
            end else begin
               s_valid[ch] = (qin[ch].size() > 0);
            end
            if (qin[ch].size() > 0) begin
               s_data[ch*PW +: PW] = qin[ch][0].d;
               s_last[ch]          = qin[ch][0].l;
            end else begin
               s_data[ch*PW +: PW] = '0;
               s_last[ch]          = 1'b0;
            end
         end
         m_ready = (mrdy_pat.size() > 0) ? mrdy_pat.pop_front() : 1'b1;
      end
   end

   // Per-cycle compare against the scoreboard and the handshake rules.
   initial begin
      bit        prev_stall;
      out_beat_t prev;
      out_beat_t e;
      int        in_ch;
      int        last_end;
      prev_stall = 1'b0;
      in_ch      = -1;
      last_end   = -1;
      forever begin
         @(negedge clk);
         if (!chk_en) begin
            prev_stall = 1'b0;
            in_ch      = -1;
            last_end   = -1;
            continue;
         end
         chk("tready_onehot0", 64'($countones(s_ready_a) <= 1), 64'd1);
         if (s_ready_a != '0 && m_valid_a) chk("tready_tracks_mready", 64'(m_ready), 64'd1);
         if (prev_stall) begin
            chk("stall_valid", 64'(m_valid_a), 64'd1);
            chk("stall_data", 64'(m_data_a), 64'(prev.d));
            chk("stall_last", 64'(m_last_a), 64'(prev.l));
            chk("stall_dest", 64'(m_dest_a), 64'(prev.dest));
         end
         for (int ch = 0; ch < NCH; ch++) begin
            if (s_valid[ch] && s_ready_a[ch]) begin
               if (in_ch < 0) begin
                  if (chk_gap && last_end >= 0) chk("inter_pkt_gap", 64'(cyc - last_end), 64'd2);
                  in_ch = ch;
               end else begin
                  chk("grant_lock", 64'(ch), 64'(in_ch));
               end
               if (s_last[ch]) begin
                  in_ch    = -1;
                  last_end = cyc;
               end
            end
         end
         if (m_valid_a && m_ready) begin
            if (qexp.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat actual=%0h required=none", m_data_a);
            end else begin
               e = qexp.pop_front();
               chk("out_data", 64'(m_data_a), 64'(e.d));
               chk("out_last", 64'(m_last_a), 64'(e.l));
               chk("out_dest", 64'(m_dest_a), 64'(e.dest));
            end
         end
         prev_stall = m_valid_a & ~m_ready;
         prev.d     = m_data_a;
         prev.l     = m_last_a;
         prev.dest  = m_dest_a;
      end
   end

   initial begin
      int v_cyc;
      int n;
      for (int ch = 0; ch < NCH; ch++) cnt_model[ch] = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_m_valid", 64'(m_valid_a), 64'd0);
      chk("rst_m_data", 64'(m_data_a), 64'd0);
      chk("rst_m_last", 64'(m_last_a), 64'd0);
      chk("rst_m_dest", 64'(m_dest_a), 64'd0);
      chk("rst_s_ready", 64'(s_ready_a), 64'd0);
      chk("rst_cnt", 64'(|cnt_a), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // Fairness: two 3-beat packets per channel, all valid together.
      chk_gap = 1'b1;
      for (int p = 0; p < 2; p++)
         for (int ch = 0; ch < NCH; ch++)
            push_pkt(ch, 8'(ch*16 + p*4), 3, -1, 0);
      wait_done("fair", 200);
      chk_gap = 1'b0;
      for (int ch = 0; ch < NCH; ch++) chk($sformatf("fair_lit_ch%0d", ch), 64'(cnt_a[ch*CW +: CW]), 64'd2);
      chk_cnt("fair");

      // Single packet on channel 2 and its accept latency.
      @(negedge clk);
      push_pkt(2, 8'hA0, 4, -1, 0);
      n = 0;
      while (!s_valid[2] && n < 20) begin @(negedge clk); n++; end
      v_cyc = cyc;
      n = 0;
      while (!m_valid_a && n < 20) begin @(negedge clk); n++; end
      chk("latency", 64'(cyc - v_cyc), 64'd2);
      chk("first_data_lit", 64'(m_data_a), 64'hA0);
      chk("first_dest_lit", 64'(m_dest_a), 64'd2);
      wait_done("single", 100);
      chk("single_lit_cnt2", 64'(cnt_a[2*CW +: CW]), 64'd3);
      chk_cnt("single");

      // Backpressure on a 5-beat packet.
      @(negedge clk);
      for (int i = 0; i < 16; i++) mrdy_pat.push_back((i % 4 == 0) || (i % 4 == 3));
      push_pkt(3, 8'hC0, 5, -1, 0);
      wait_done("bp", 200);
      chk_cnt("bp");

      // Valid gap on granted channel 0 while channel 1 requests.
      @(negedge clk);
      push_pkt(0, 8'hD0, 4, 2, 3);
      push_pkt(1, 8'hE0, 2, -1, 0);
      wait_done("gap", 200);
      chk_cnt("gap");

      // Asynchronous reset in the middle of a channel 2 packet.
      @(negedge clk);
      push_pkt(2, 8'h50, 8, -1, 0);
      repeat (5) @(negedge clk);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", 64'(m_valid_a), 64'd0);
      chk("arst_m_data", 64'(m_data_a), 64'd0);
      chk("arst_m_last", 64'(m_last_a), 64'd0);
      chk("arst_m_dest", 64'(m_dest_a), 64'd0);
      chk("arst_s_ready", 64'(s_ready_a), 64'd0);
      chk("arst_cnt32", 64'(|cnt_a), 64'd0);
      chk("arst_cnt4", 64'(|cnt_b), 64'd0);
      for (int ch = 0; ch < NCH; ch++) begin
         qin[ch].delete();
         head_wait[ch] = 0;
         cnt_model[ch] = 0;
      end
      qexp.delete();
      mrdy_pat.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      push_pkt(1, 8'h10, 2, -1, 0);
      push_pkt(3, 8'h30, 2, -1, 0);
      wait_done("post_rst", 100);
      chk("post_rst_lit_cnt1", 64'(cnt_a[1*CW +: CW]), 64'd1);
      chk("post_rst_lit_cnt3", 64'(cnt_a[3*CW +: CW]), 64'd1);
      chk_cnt("post_rst");

      // Seventeen one-beat packets on channel 0 saturate the 4-bit counter.
      @(negedge clk);
      for (int i = 0; i < 17; i++) push_pkt(0, 8'(8'h70 + i), 1, -1, 0);
      wait_done("sat", 400);
      chk("sat_lit_cnt4", 64'(cnt_b[0 +: CWB]), 64'd15);
      chk("sat_lit_cnt32", 64'(cnt_a[0 +: CW]), 64'd17);
      chk_cnt("sat");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_snoop_arbiter.md
Name: axis_snoop_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_CH snoop-FIFO AXIS master outputs into one AXIS stream.
- Sits directly downstream of the per-channel snoop FIFOs, which only ever present whole packets.
- Never interleaves beats of different packets.
- Tags every output beat with its source channel on TDEST and keeps a per-channel count of forwarded packets.

Parameters:
- PORT_WIDTH, 8, data width per channel and on the output.
- NUM_CH, 4, number of input channels (1..16).
- CNT_WIDTH, 32, width of each per-channel packet counter.
- Derived: CH_W = max(1, clog2(NUM_CH)).

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  reset; asynchronous, active-low.
- S_AXIS_TVALID  in  NUM_CH  per-channel valid.
- S_AXIS_TREADY  out  NUM_CH  per-channel ready.
- S_AXIS_TDATA  in  NUM_CH*PORT_WIDTH  channel i occupies bits [i*PORT_WIDTH +: PORT_WIDTH].
- S_AXIS_TLAST  in  NUM_CH  per-channel last.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  PORT_WIDTH  merged data.
- M_AXIS_TLAST  out  1  merged last.
- M_AXIS_TDEST  out  CH_W  source channel of the current beat.
- PKT_CNT  out  NUM_CH*CNT_WIDTH  per-channel forwarded-packet counters, same packing as S_AXIS_TDATA.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, rr_ptr=0, grant=0.
  - Output register empty; M_AXIS_TVALID=0; M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TDEST = 0.
  - S_AXIS_TREADY=0; all PKT_CNT=0.
- FSM states: IDLE, PKT.
- IDLE:
  - If any S_AXIS_TVALID is set, pick the first requester found scanning rr_ptr, rr_ptr+1, … mod NUM_CH.
  - Register it as grant and go to PKT.
  - S_AXIS_TREADY is all-zero in IDLE.
  - The first beat is accepted no earlier than the cycle after the request is seen.
- PKT:
  - S_AXIS_TREADY[grant] = out_empty | M_AXIS_TREADY. All other TREADY bits are 0.
  - A beat is accepted when S_AXIS_TVALID[grant] & S_AXIS_TREADY[grant].
  - On an accepted beat with TLAST: go to IDLE, rr_ptr <= (grant+1) mod NUM_CH, PKT_CNT[grant] += 1.
- Grant lock:
  - Held until the TLAST beat regardless of TVALID gaps.
  - Other channels' valids are ignored mid-packet.
- Inter-packet gap: exactly one idle input cycle (the IDLE state) between packets; this is accepted.
- Output register (single stage, full throughput):
  - An accepted beat loads TDATA, TLAST and TDEST=grant, and sets M_AXIS_TVALID.
  - M_AXIS_TVALID clears on M_AXIS_TREADY when no new beat is loaded that cycle.
  - Output contents are stable while M_AXIS_TVALID & ~M_AXIS_TREADY.
- Latency: input accept to M_AXIS_TVALID is 1 cycle.
- Counters:
  - Saturate at 2^CNT_WIDTH-1 (no wrap).
  - Increment on the input-side TLAST accept, not the output handshake.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,NUM_CH-1,0.
- NUM_CH=1: the arbiter degenerates to a pass-through with the IDLE gap; TDEST is always 0.
- Reset mid-packet: the partial packet is dropped from the arbiter's view; the upstream FIFO state is not this block's concern.

Decomposition:
- Package axis_snoop_pkg:
  - state enum snoop_arb_state_t {IDLE, PKT}.
  - Function computing CH_W from NUM_CH.
  - Counter saturation helper.
- Sub-module snoop_rr_pick:
  - Purely combinational.
  - Inputs: request vector and rr_ptr.
  - Outputs: grant index and any_req.
  - Contains the rotate, priority-encode and unrotate logic.

Test Plan:
- Single packet, channel 2, 4 beats 0xA0..0xA3, M_AXIS_TREADY=1 -> output 0xA0..0xA3, TLAST on 0xA3, TDEST=2 on every beat, PKT_CNT[2]=1, first M_AXIS_TVALID 2 cycles after S_AXIS_TVALID rises.
- All 4 channels each holding two 3-beat packets -> output packet order by channel 0,1,2,3,0,1,2,3; no interleaving; one IDLE cycle between packets; PKT_CNT = {2,2,2,2}.
- Backpressure: M_AXIS_TREADY toggled 1,0,0,1 during a 5-beat packet -> no beat lost or duplicated; TDATA held stable while stalled; S_AXIS_TREADY[grant] tracks M_AXIS_TREADY when the register is full.
- Mid-packet TVALID gap on the granted channel while another channel requests -> grant held; the other channel is served only after the TLAST beat.
- Async reset asserted mid-packet (not clock-aligned) -> outputs 0 immediately; after release the next arbitration starts at rr_ptr=0 and counters read 0.
- CNT_WIDTH=4, 17 one-beat packets on channel 0 -> PKT_CNT[0]=15 (saturated).
